// File: rtl/apb_kronus_pkg.sv
// Shared types and register map for the kronus APB requester, completer and bench.
// Pure declarations: no logic, no latency, no flow control.
package apb_kronus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_req_state_e;

    localparam logic [7:0] CONTROL = 8'h10;
    localparam logic [7:0] STATUS  = 8'h20;

endpackage

// File: rtl/apb_kronus_timeout.sv
// Saturating wait-state counter; expired_o flags the increment that reaches TIMEOUT_CYCLES (0 disables).
// Combinational expired_o from the registered count; no backpressure.
module apb_kronus_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic expired_o
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign expired_o = (TIMEOUT_CYCLES != 0) && inc_i && !clr_i && (cnt_d == LIMIT);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/apb_kronus_requester.sv
// APB4 requester: one command -> one APB transfer -> one response; 3 cycles handshake-to-rsp plus wait states.
// One transfer in flight: cmd_ready only in IDLE; response held until rsp_ready, APB idle meanwhile.
module apb_kronus_requester
    import apb_kronus_pkg::*;
#(
    parameter int unsigned ADDR_W         = 8,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                pclk,
    input  logic                preset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic                cmd_write,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_strb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                rsp_timeout,
    output logic                psel,
    output logic                penable,
    output logic                pwrite,
    output logic [ADDR_W-1:0]   paddr,
    output logic [DATA_W-1:0]   pwdata,
    output logic [DATA_W/8-1:0] pstrb,
    input  logic [DATA_W-1:0]   prdata,
    input  logic                pready,
    input  logic                pslverr
);

    localparam int unsigned STRB_W = DATA_W / 8;

    apb_req_state_e state_q, state_d;

    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic              pwrite_q, pwrite_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic [STRB_W-1:0] pstrb_q, pstrb_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              rsp_timeout_q, rsp_timeout_d;

    logic cnt_clr;
    logic cnt_inc;
    logic timeout_hit;

    apb_kronus_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i     (pclk),
        .rst_i     (preset),
        .clr_i     (cnt_clr),
        .inc_i     (cnt_inc),
        .expired_o (timeout_hit)
    );

    always_comb begin
        state_d       = state_q;
        paddr_d       = paddr_q;
        pwrite_d      = pwrite_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        cnt_clr       = 1'b0;
        cnt_inc       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    paddr_d  = cmd_addr;
                    pwrite_d = cmd_write;
                    // Reads carry no strobes and leave the write-data bus untouched.
                    if (cmd_write) begin
                        pwdata_d = cmd_wdata;
                        pstrb_d  = cmd_strb;
                    end else begin
                        pstrb_d  = '0;
                    end
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (pready) begin
                    rsp_rdata_d   = (pwrite_q || pslverr) ? '0 : prdata;
                    rsp_err_d     = pslverr;
                    rsp_timeout_d = 1'b0;
                    state_d       = RESP;
                end else begin
                    cnt_inc = 1'b1;
                    if (timeout_hit) begin
                        rsp_rdata_d   = '0;
                        rsp_err_d     = 1'b1;
                        rsp_timeout_d = 1'b1;
                        state_d       = RESP;
                    end
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    cnt_clr = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q       <= IDLE;
            paddr_q       <= '0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            paddr_q       <= paddr_d;
            pwrite_q      <= pwrite_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign cmd_ready   = (state_q == IDLE) && !preset;
    assign psel        = (state_q == SETUP) || (state_q == ACCESS);
    assign penable     = (state_q == ACCESS);
    assign rsp_valid   = (state_q == RESP);
    assign pwrite      = pwrite_q;
    assign paddr       = paddr_q;
    assign pwdata      = pwdata_q;
    assign pstrb       = pstrb_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_kronus_requester.sv
// Bench for apb_kronus_requester paired with a programmable-wait APB completer model.
// Expected responses are queued when a command is issued and compared when the response appears.
module tb_apb_kronus_requester;
    import apb_kronus_pkg::*;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 8;

    logic          pclk = 1'b0;
    logic          preset;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [SW-1:0] cmd_strb;
    logic          rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [DW-1:0] rsp_rdata;
    logic          psel, penable, pwrite, pready, pslverr;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata, prdata;
    logic [SW-1:0] pstrb;

    always #5 pclk = ~pclk;

    apb_kronus_requester #(
        .ADDR_W (AW), .DATA_W (DW), .TIMEOUT_CYCLES (TO)
    ) dut (
        .pclk (pclk), .preset (preset),
        .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_addr (cmd_addr),
        .cmd_write (cmd_write), .cmd_wdata (cmd_wdata), .cmd_strb (cmd_strb),
        .rsp_valid (rsp_valid), .rsp_ready (rsp_ready), .rsp_rdata (rsp_rdata),
        .rsp_err (rsp_err), .rsp_timeout (rsp_timeout),
        .psel (psel), .penable (penable), .pwrite (pwrite), .paddr (paddr),
        .pwdata (pwdata), .pstrb (pstrb), .prdata (prdata), .pready (pready),
        .pslverr (pslverr)
    );

    // Completer model: ready after cfg_wait ACCESS cycles with pready low.
    int            cfg_wait = 0;
    logic          cfg_err = 1'b0;
    logic [DW-1:0] cfg_rdata = '0;
    int            acc_cnt = 0;

    always @(posedge pclk) begin
        if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
        else                            acc_cnt <= 0;
    end
    assign pready  = psel && penable && (acc_cnt >= cfg_wait);
    assign pslverr = pready && cfg_err;
    assign prdata  = pready ? cfg_rdata : 32'hBAD0_BAD0;

    int   proto_viol = 0;
    logic prev_setup = 1'b0;
    always @(negedge pclk) begin
        if (penable && !psel) proto_viol++;
        if (prev_setup && !(psel && penable)) proto_viol++;
        prev_setup = psel && !penable;
    end

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        logic          to;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        int            acc_wait;
        int            lat;
        int            n_psel;
        int            n_access;
        logic          setup_ok;
        logic          stable;
        logic          hold_ok;
        logic          bound_ok;
        logic [DW-1:0] rd;
        logic          er;
        logic          to;
        logic [DW-1:0] s_wdata;
        logic [SW-1:0] s_strb;
    } res_t;

    int n_checks = 0;
    int n_pass   = 0;

    // Called just after a rising edge. Issues one command and follows it to its response handshake.
    task automatic run_xfer(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] wd,
                            input logic [SW-1:0] st, input int hold, input logic keep_valid,
                            output res_t r);
        logic [AW-1:0] a0;
        r = '{default: '0};
        r.stable = 1'b1; r.hold_ok = 1'b1; r.bound_ok = 1'b1;
        cmd_addr = a; cmd_write = w; cmd_wdata = wd; cmd_strb = st; cmd_valid = 1'b1;
        rsp_ready = 1'b0;
        @(negedge pclk);
        while (!cmd_ready && r.acc_wait < 100) begin
            r.acc_wait++;
            @(negedge pclk);
        end
        if (!cmd_ready) begin r.bound_ok = 1'b0; cmd_valid = 1'b0; return; end
        @(posedge pclk); #1;
        if (!keep_valid) cmd_valid = 1'b0;
        @(negedge pclk);
        r.lat = 1;
        r.setup_ok = psel && !penable;
        a0 = paddr; r.s_strb = pstrb; r.s_wdata = pwdata;
        while (!rsp_valid && r.lat < 100) begin
            if (psel) r.n_psel++;
            if (psel && penable) r.n_access++;
            if (psel && (paddr !== a0 || pstrb !== r.s_strb || pwdata !== r.s_wdata || pwrite !== w))
                r.stable = 1'b0;
            @(negedge pclk);
            r.lat++;
        end
        if (!rsp_valid) begin r.bound_ok = 1'b0; return; end
        r.rd = rsp_rdata; r.er = rsp_err; r.to = rsp_timeout;
        for (int i = 0; i < hold; i++) begin
            @(negedge pclk);
            if (!rsp_valid || rsp_rdata !== r.rd || rsp_err !== r.er || rsp_timeout !== r.to ||
                psel || cmd_ready)
                r.hold_ok = 1'b0;
        end
        rsp_ready = 1'b1;
        @(posedge pclk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        preset = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_addr = '0; cmd_write = 1'b0; cmd_wdata = '0; cmd_strb = '0;
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        n_checks++;
        if ({psel, penable, pwrite, paddr, pwdata, pstrb, rsp_valid, rsp_rdata, rsp_err, rsp_timeout} !== '0)
            $display("FAIL reset_outputs got psel=%b pen=%b paddr=%h pwdata=%h rsp_valid=%b required all 0",
                     psel, penable, paddr, pwdata, rsp_valid);
        else n_pass++;
        n_checks++; if (cmd_ready !== 1'b0) $display("FAIL reset_cmd_ready_held got %b required 0", cmd_ready); else n_pass++;
        @(posedge pclk); #1;
        preset = 1'b0;
        @(negedge pclk);
        n_checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready_release got %b required 1", cmd_ready); else n_pass++;
        @(posedge pclk); #1;
    endtask

    task automatic test_write();
        res_t r; exp_t e;
        cfg_wait = 0; cfg_err = 1'b0; cfg_rdata = 32'hCAFE_F00D;
        sb.push_back('{rdata: 32'h0, err: 1'b0, to: 1'b0});
        run_xfer(CONTROL, 1'b1, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, r);
        e = sb.pop_front();
        n_checks++; if (!r.bound_ok) $display("FAIL wr_bound transfer did not complete"); else n_pass++;
        n_checks++; if (r.setup_ok !== 1'b1) $display("FAIL wr_setup got %b required psel=1 penable=0", r.setup_ok); else n_pass++;
        n_checks++; if (r.n_access !== 1) $display("FAIL wr_access_cycles got %0d required 1", r.n_access); else n_pass++;
        n_checks++; if (r.lat !== 3) $display("FAIL wr_latency got %0d required 3", r.lat); else n_pass++;
        n_checks++; if (r.s_wdata !== 32'hDEAD_BEEF || r.s_strb !== 4'hF) $display("FAIL wr_bus got %h/%h required deadbeef/f", r.s_wdata, r.s_strb); else n_pass++;
        n_checks++; if ({r.rd, r.er, r.to} !== {e.rdata, e.err, e.to}) $display("FAIL wr_rsp got %h/%b/%b required %h/%b/%b", r.rd, r.er, r.to, e.rdata, e.err, e.to); else n_pass++;
    endtask

    task automatic test_read_wait();
        res_t r; exp_t e;
        cfg_wait = 2; cfg_err = 1'b0; cfg_rdata = 32'h1234_5678;
        sb.push_back('{rdata: 32'h1234_5678, err: 1'b0, to: 1'b0});
        run_xfer(STATUS, 1'b0, 32'hFFFF_FFFF, 4'hF, 0, 1'b0, r);
        e = sb.pop_front();
        n_checks++; if (r.lat !== 5) $display("FAIL rd_latency got %0d required 5", r.lat); else n_pass++;
        n_checks++; if (r.n_psel !== 4 || !r.stable) $display("FAIL rd_addr_stable got psel_cycles=%0d stable=%b required 4/1", r.n_psel, r.stable); else n_pass++;
        n_checks++; if (r.s_strb !== 4'h0) $display("FAIL rd_pstrb got %h required 0", r.s_strb); else n_pass++;
        n_checks++; if (r.s_wdata !== 32'hDEAD_BEEF) $display("FAIL rd_pwdata_hold got %h required deadbeef", r.s_wdata); else n_pass++;
        n_checks++; if ({r.rd, r.er, r.to} !== {e.rdata, e.err, e.to}) $display("FAIL rd_rsp got %h/%b/%b required %h/%b/%b", r.rd, r.er, r.to, e.rdata, e.err, e.to); else n_pass++;
    endtask

    task automatic test_slverr();
        res_t r; exp_t e;
        cfg_wait = 0; cfg_err = 1'b1; cfg_rdata = 32'h7777_7777;
        sb.push_back('{rdata: 32'h0, err: 1'b1, to: 1'b0});
        run_xfer(CONTROL, 1'b1, 32'h0000_00A5, 4'h1, 0, 1'b0, r);
        e = sb.pop_front();
        n_checks++; if ({r.rd, r.er, r.to} !== {e.rdata, e.err, e.to}) $display("FAIL slverr_rsp got %h/%b/%b required %h/%b/%b", r.rd, r.er, r.to, e.rdata, e.err, e.to); else n_pass++;
        cfg_err = 1'b0;
    endtask

    task automatic test_timeout();
        res_t r; exp_t e;
        cfg_wait = 1000; cfg_rdata = 32'h55AA_55AA;
        sb.push_back('{rdata: 32'h0, err: 1'b1, to: 1'b1});
        run_xfer(STATUS, 1'b0, 32'h0, 4'h0, 0, 1'b0, r);
        e = sb.pop_front();
        n_checks++; if (r.n_access !== TO || r.lat !== TO + 2) $display("FAIL to_cycles got access=%0d lat=%0d required %0d/%0d", r.n_access, r.lat, TO, TO + 2); else n_pass++;
        n_checks++; if ({r.rd, r.er, r.to} !== {e.rdata, e.err, e.to}) $display("FAIL to_rsp got %h/%b/%b required %h/%b/%b", r.rd, r.er, r.to, e.rdata, e.err, e.to); else n_pass++;
        cfg_wait = TO - 1;
        sb.push_back('{rdata: 32'h55AA_55AA, err: 1'b0, to: 1'b0});
        run_xfer(STATUS, 1'b0, 32'h0, 4'h0, 0, 1'b0, r);
        e = sb.pop_front();
        n_checks++; if (r.n_access !== TO) $display("FAIL to_edge_cycles got %0d required %0d", r.n_access, TO); else n_pass++;
        n_checks++; if ({r.rd, r.er, r.to} !== {e.rdata, e.err, e.to}) $display("FAIL to_edge_rsp got %h/%b/%b required %h/%b/%b", r.rd, r.er, r.to, e.rdata, e.err, e.to); else n_pass++;
    endtask

    task automatic test_back_to_back();
        res_t r; exp_t e;
        cfg_wait = 0; cfg_rdata = 32'hA1B2_C3D4;
        sb.push_back('{rdata: 32'hA1B2_C3D4, err: 1'b0, to: 1'b0});
        run_xfer(CONTROL, 1'b0, 32'h0, 4'h0, 4, 1'b1, r);
        e = sb.pop_front();
        n_checks++; if (r.hold_ok !== 1'b1) $display("FAIL bp_hold got %b required stable rsp, no psel, cmd_ready=0", r.hold_ok); else n_pass++;
        n_checks++; if ({r.rd, r.er, r.to} !== {e.rdata, e.err, e.to}) $display("FAIL bp_rsp got %h/%b/%b required %h/%b/%b", r.rd, r.er, r.to, e.rdata, e.err, e.to); else n_pass++;
        sb.push_back('{rdata: 32'h0, err: 1'b0, to: 1'b0});
        run_xfer(STATUS, 1'b1, 32'h0000_0003, 4'h3, 0, 1'b0, r);
        e = sb.pop_front();
        n_checks++; if (r.acc_wait !== 0 || r.lat !== 3) $display("FAIL b2b_accept got wait=%0d lat=%0d required 0/3", r.acc_wait, r.lat); else n_pass++;
        n_checks++; if ({r.rd, r.er, r.to} !== {e.rdata, e.err, e.to}) $display("FAIL b2b_rsp got %h/%b/%b required %h/%b/%b", r.rd, r.er, r.to, e.rdata, e.err, e.to); else n_pass++;
    endtask

    task automatic test_reset_mid();
        res_t r; exp_t e;
        int guard;
        cfg_wait = 1; cfg_rdata = 32'h0BAD_F00D;
        cmd_addr = CONTROL; cmd_write = 1'b0; cmd_strb = '0; cmd_valid = 1'b1;
        @(negedge pclk);
        guard = 0;
        while (!cmd_ready && guard < 50) begin guard++; @(negedge pclk); end
        @(posedge pclk); #1;
        cmd_valid = 1'b0;
        @(negedge pclk);
        guard = 0;
        while (!penable && guard < 50) begin guard++; @(negedge pclk); end
        n_checks++; if (penable !== 1'b1) $display("FAIL rst_mid_reach_access got penable=%b required 1", penable); else n_pass++;
        preset = 1'b1;
        @(posedge pclk); #1;
        n_checks++; if ({psel, penable, rsp_valid, cmd_ready} !== 4'b0) $display("FAIL rst_mid_abort got psel=%b pen=%b rsp_valid=%b cmd_ready=%b required 0000", psel, penable, rsp_valid, cmd_ready); else n_pass++;
        n_checks++; if (paddr !== '0) $display("FAIL rst_mid_paddr got %h required 0", paddr); else n_pass++;
        preset = 1'b0;
        #1;
        n_checks++; if (cmd_ready !== 1'b1) $display("FAIL rst_mid_ready got %b required 1", cmd_ready); else n_pass++;
        @(posedge pclk); #1;
        sb.push_back('{rdata: 32'h0BAD_F00D, err: 1'b0, to: 1'b0});
        run_xfer(CONTROL, 1'b0, 32'h0, 4'h0, 0, 1'b0, r);
        e = sb.pop_front();
        n_checks++; if (r.lat !== 4) $display("FAIL rst_mid_fresh_latency got %0d required 4", r.lat); else n_pass++;
        n_checks++; if ({r.rd, r.er, r.to} !== {e.rdata, e.err, e.to}) $display("FAIL rst_mid_fresh_rsp got %h/%b/%b required %h/%b/%b", r.rd, r.er, r.to, e.rdata, e.err, e.to); else n_pass++;
    endtask

    task automatic test_protocol();
        n_checks++; if (proto_viol !== 0) $display("FAIL protocol_violations got %0d required 0", proto_viol); else n_pass++;
        n_checks++; if (sb.size() !== 0) $display("FAIL scoreboard_leftover got %0d required 0", sb.size()); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_slverr();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_protocol();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
